// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and sizes for the packet router
// Contents: state_t (router FSM states), FIFO_DEPTH, DATA_W, LEN_W, PTR_W.
package router_pkg;

    localparam int FIFO_DEPTH = 16;
    localparam int DATA_W     = 8;
    localparam int LEN_W      = 6;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        LOAD_DATA    = 2'd1,
        LOAD_PARITY  = 2'd2,
        CHECK_PARITY = 2'd3
    } state_t;

endpackage

// File: rtl/router_if.sv
// rtl/router_if.sv - writer/reader bus of the packet router
// Signals: data_in, pkt_valid, read_enb (driven by master); data_out, vld_out,
// busy, error (driven by slave). master = writer/reader side, slave = router.
interface router_if;
    import router_pkg::*;

    logic [DATA_W-1:0] data_in;
    logic              pkt_valid;
    logic              read_enb;
    logic [DATA_W-1:0] data_out;
    logic              vld_out;
    logic              busy;
    logic              error;

    modport master (
        output data_in, pkt_valid, read_enb,
        input  data_out, vld_out, busy, error
    );

    modport slave (
        input  data_in, pkt_valid, read_enb,
        output data_out, vld_out, busy, error
    );

endinterface

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - 16x8 synchronous FIFO with registered read data
// Ports: clock, rst (sync, active-high), push/din (write), pop (read request),
// full, empty, dout (byte popped on the previous pop, held otherwise).
// Push while full and pop while empty are ignored.
module router_fifo
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] dout
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers are PTR_W bits wide so they wrap modulo FIFO_DEPTH naturally.
    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout   <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/router_modport.sv
// rtl/router_modport.sv - packet router: framing FSM, parity check, output FIFO
// Ports: clock, rst (sync, active-high), bus (router_if.slave: data_in,
// pkt_valid, read_enb in; data_out, vld_out, busy, error out).
// Packet = header (L in [7:2]), L payload bytes, parity byte; all bytes are
// stored in the FIFO. Parity checking is built only with ROUTER_PARITY_CHECK_EN;
// otherwise error is tied low.
module router_modport
    import router_pkg::*;
(
    input  logic     clock,
    input  logic     rst,
    router_if.slave  bus
);

    state_t state;
    state_t state_next;
    logic   push;
    logic   full;
    logic   empty;

    router_fifo u_fifo (
        .clock (clock),
        .rst   (rst),
        .push  (push),
        .din   (bus.data_in),
        .pop   (bus.read_enb),
        .full  (full),
        .empty (empty),
        .dout  (bus.data_out)
    );

    assign bus.busy    = full || (state == CHECK_PARITY);
    assign bus.vld_out = !empty;

    always_ff @(posedge clock) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // push is only raised when busy is low, so no byte is ever taken while busy.
    // Leaving LOAD_DATA on pkt_valid=0 stores nothing; the parity byte is the
    // data_in value at the next non-busy cycle in LOAD_PARITY.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.pkt_valid && !bus.busy) begin
                    push       = 1'b1;
                    state_next = LOAD_DATA;
                end
            end
            LOAD_DATA: begin
                if (!bus.pkt_valid) begin
                    state_next = LOAD_PARITY;
                end else if (!bus.busy) begin
                    push = 1'b1;
                end
            end
            LOAD_PARITY: begin
                if (!bus.busy) begin
                    push       = 1'b1;
                    state_next = CHECK_PARITY;
                end
            end
            CHECK_PARITY: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef ROUTER_PARITY_CHECK_EN
    logic [DATA_W-1:0] parity_calc;
    logic [DATA_W-1:0] parity_rx;
    logic              error_q;

    // parity_calc restarts from the header so a packet cut short by reset
    // leaves no residue in the next packet's check.
    always_ff @(posedge clock) begin
        if (rst) begin
            parity_calc <= '0;
            parity_rx   <= '0;
            error_q     <= 1'b0;
        end else begin
            if (push) begin
                case (state)
                    IDLE:        parity_calc <= bus.data_in;
                    LOAD_DATA:   parity_calc <= parity_calc ^ bus.data_in;
                    LOAD_PARITY: parity_rx   <= bus.data_in;
                    default:     parity_calc <= parity_calc;
                endcase
            end
            if (push && (state == IDLE)) begin
                error_q <= 1'b0;
            end else if (state == CHECK_PARITY) begin
                error_q <= (parity_calc != parity_rx);
            end
        end
    end

    assign bus.error = error_q;
`else
    assign bus.error = 1'b0;
`endif

endmodule

// File: tb/tb_router_modport.sv
// tb/tb_router_modport.sv - self-checking bench for router_modport
module tb_router_modport;
    import router_pkg::*;

    logic clock = 1'b0;
    logic rst   = 1'b1;

    router_if bus ();

    router_modport dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic       exp_err;
    logic [7:0] last_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s timeout waiting on DUT", tag);
    endtask

    task automatic wait_not_busy(input string tag);
        int n = 0;
        while (bus.busy !== 1'b0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (n >= 300) timeout_fail(tag);
    endtask

    // Byte is presented at a negedge and taken on the next non-busy posedge.
    task automatic put_byte(input logic [7:0] b, input logic v);
        bus.data_in   = b;
        bus.pkt_valid = v;
        wait_not_busy("put_byte");
        @(negedge clock);
    endtask

    task automatic send_packet(input logic [7:0] hdr, input logic [7:0] pl[$], input logic [7:0] par);
        logic [7:0] x;
        x = hdr;
        exp_q.push_back(hdr);
        foreach (pl[i]) begin
            x ^= pl[i];
            exp_q.push_back(pl[i]);
        end
        exp_q.push_back(par);
`ifdef ROUTER_PARITY_CHECK_EN
        exp_err = (par != x);
`else
        exp_err = 1'b0;
`endif
        put_byte(hdr, 1'b1);
        check("err_clear_on_header", bus.error, 0);
        foreach (pl[i]) put_byte(pl[i], 1'b1);
        // Hold the parity byte across the falling pkt_valid and the capture cycle.
        bus.pkt_valid = 1'b0;
        bus.data_in   = par;
        wait_not_busy("parity_a");
        @(negedge clock);
        wait_not_busy("parity_b");
        @(negedge clock);
    endtask

    task automatic drain(input int n, input string tag);
        int   got = 0;
        int   cyc = 0;
        logic v;
        logic [7:0] e;
        bus.read_enb = 1'b1;
        while (got < n && cyc < 400) begin
            v = bus.vld_out;
            @(negedge clock);
            cyc++;
            if (v) begin
                e = 8'h00;
                if (exp_q.size() > 0) e = exp_q.pop_front();
                check(tag, bus.data_out, e);
                last_out = e;
                got++;
            end
        end
        bus.read_enb = 1'b0;
        if (got < n) timeout_fail(tag);
    endtask

    initial begin
        logic [7:0] pl[$];
        logic [7:0] hdr;
        logic [7:0] par;
        int         len;

        bus.data_in   = 8'h00;
        bus.pkt_valid = 1'b0;
        bus.read_enb  = 1'b0;
        last_out      = 8'h00;
        exp_err       = 1'b0;
        repeat (2) @(negedge clock);
        rst = 1'b0;

        check("rst_data_out", bus.data_out, 0);
        check("rst_vld_out", bus.vld_out, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_error", bus.error, 0);

        // Single good packet
        pl = '{8'h11, 8'h22, 8'h33};
        send_packet(8'h0C, pl, 8'h0C);
        repeat (2) @(negedge clock);
        check("good_error", bus.error, exp_err);
        check("good_vld", bus.vld_out, 1);
        drain(5, "good_data");
        check("good_vld_empty", bus.vld_out, 0);

        // Read request on empty FIFO
        bus.read_enb = 1'b1;
        repeat (3) @(negedge clock);
        bus.read_enb = 1'b0;
        check("empty_vld", bus.vld_out, 0);
        check("empty_data_hold", bus.data_out, last_out);

        // Bad parity, then a good packet clears error at its header
        send_packet(8'h0C, pl, 8'h00);
        repeat (2) @(negedge clock);
        check("bad_error", bus.error, exp_err);
        drain(5, "bad_data");
        check("bad_error_held", bus.error, exp_err);
        pl = '{8'hA5};
        send_packet(8'h04, pl, 8'h04 ^ 8'hA5);
        repeat (2) @(negedge clock);
        check("after_bad_error", bus.error, 0);
        drain(3, "after_bad_data");

        // Full FIFO: 22-byte packet with the reader held off
        pl = {};
        par = 8'h50;
        for (int i = 0; i < 20; i++) begin
            pl.push_back(8'($urandom));
            par ^= pl[i];
        end
        fork
            send_packet(8'h50, pl, par);
            begin
                repeat (40) @(negedge clock);
                check("full_busy", bus.busy, 1);
                check("full_vld", bus.vld_out, 1);
                drain(22, "full_data");
            end
        join
        repeat (2) @(negedge clock);
        check("full_error", bus.error, exp_err);
        check("full_busy_clear", bus.busy, 0);

        // Reset in the middle of a packet
        put_byte(8'h0C, 1'b1);
        put_byte(8'h11, 1'b1);
        put_byte(8'h22, 1'b1);
        bus.pkt_valid = 1'b0;
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        exp_q.delete();
        check("midrst_vld", bus.vld_out, 0);
        check("midrst_error", bus.error, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_data_out", bus.data_out, 0);
        pl = '{8'h5A};
        send_packet(8'h04, pl, 8'h04 ^ 8'h5A);
        repeat (2) @(negedge clock);
        check("midrst_next_error", bus.error, 0);
        drain(3, "midrst_next_data");

        // Random packets; some with corrupted parity
        for (int k = 0; k < 8; k++) begin
            len = $urandom_range(0, 14);
            hdr = {6'(len), 2'($urandom)};
            pl  = {};
            par = hdr;
            for (int i = 0; i < len; i++) begin
                pl.push_back(8'($urandom));
                par ^= pl[i];
            end
            if ($urandom_range(0, 2) == 0) par ^= 8'($urandom_range(1, 255));
            send_packet(hdr, pl, par);
            repeat (2) @(negedge clock);
            check("rand_error", bus.error, exp_err);
            drain(len + 2, "rand_data");
            check("rand_vld_empty", bus.vld_out, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
